// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with register-file write-back strobe on completion.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] rd_addr,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         result,
    output logic [$clog2(WIDTH)-1:0] wr_addr,
    output logic                     wr_en
);
    localparam int AW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opd_q;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [AW-1:0]      rd_q;
    logic [CW-1:0]      cnt_q;

    logic accept;
    logic last_step;

    logic             a_signed, b_signed, a_neg, b_neg, res_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             special;
    logic [WIDTH-1:0] special_val;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] acc_step, prod_fixed;
    logic [WIDTH-1:0]   div_val, final_val;

    assign accept    = start && (state != CALC);
    assign last_step = (state == CALC) && (cnt_q == CW'(1));

    // Operand decode at issue: magnitudes, result sign, and the cases that bypass CALC.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        a_signed    = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed    = op inside {OP_MULH, OP_DIV, OP_REM};
        a_neg       = a_signed & a[WIDTH-1];
        b_neg       = b_signed & b[WIDTH-1];
        a_mag       = a_neg ? -a : a;
        b_mag       = b_neg ? -b : b;
        res_neg     = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        special     = 1'b0;
        special_val = '0;
        if (op[2] && (b == '0)) begin
            special     = 1'b1;
            special_val = op[1] ? a : '1;
        end else if ((op == OP_DIV || op == OP_REM) &&
                     (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
            special     = 1'b1;
            special_val = (op == OP_DIV) ? a : '0;
        end
    end

    // acc_q holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opd_q};
        if (op_q[2]) begin
            acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
        prod_fixed = neg_q ? -acc_step : acc_step;
        div_val    = op_q[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        if (op_q[2]) begin
            final_val = neg_q ? -div_val : div_val;
        end else if (op_q == OP_MUL) begin
            final_val = prod_fixed[WIDTH-1:0];
        end else begin
            final_val = prod_fixed[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is written with <= so every register samples pre-edge values.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_nxt = special ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC:    if (last_step) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    assign wr_en = done && (wr_addr != '0);

    // NOTE: the datapath is a handful of flops, so it is reset too; an aborted op then leaves nothing stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            opd_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
            result  <= '0;
            wr_addr <= '0;
        end else if (accept) begin
            op_q  <= op;
            neg_q <= res_neg;
            rd_q  <= rd_addr;
            cnt_q <= CW'(WIDTH);
            if (special) begin
                result  <= special_val;
                wr_addr <= rd_addr;
            end else if (op[2]) begin
                acc_q <= {{WIDTH{1'b0}}, a_mag};
                opd_q <= b_mag;
            end else begin
                acc_q <= {{WIDTH{1'b0}}, b_mag};
                opd_q <= a_mag;
            end
        end else if (state == CALC) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CW'(1);
            if (last_step) begin
                result  <= final_val;
                wr_addr <= rd_q;
            end
        end
    end
endmodule
